lights_step_scheduler: RTL and testbench

Sequencer and two-way arbiter for the dynamic LED lights block. Two requesters each ask for the colour to advance a given number of steps. The scheduler grants one request at a time, round-robin, and drives the lights' `button` input high for exactly that many clock cycles. It then holds `button` low for a fixed dwell period and reports completion. It also keeps a cycle-accurate mirror of the lights' colour register, so software and verification can track the displayed colour without reading the lights block.

---
 rtl/lights_step_scheduler.sv | 131 +++++++++++++
 tb/tb_lights_step_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lights_step_scheduler.sv
// Round-robin two-requester step sequencer for the dynamic LED lights block.
// Drives the lights' button for the granted step count, dwells, and mirrors the colour register.
module lights_step_scheduler #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned DWELL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [CNT_W-1:0] req_steps0,
  input  logic [CNT_W-1:0] req_steps1,
  output logic [1:0]       req_ready,
  output logic [1:0]       done,
  output logic             busy,
  output logic             button,
  output logic [2:0]       colour_est
);

  // Counter must hold both a step count and the dwell length.
  localparam int unsigned CW = (CNT_W > 8) ? CNT_W : 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STEP  = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             grant_q, grant_d;
  logic             ptr_q, ptr_d;
  logic [2:0]       colour_q, colour_d;
  logic             hs;
  logic             hs_idx;
  logic [CNT_W-1:0] steps_sel;

  // Accept decode; requester ~ptr wins a tie. Held off during reset so no accept is lost.
  always_comb begin
    req_ready = 2'b00;
    if (!rst && state_q == S_IDLE) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = ptr_q ? 2'b01 : 2'b10;
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign hs        = |(req_valid & req_ready);
  assign hs_idx    = req_ready[1];
  assign steps_sel = hs_idx ? req_steps1 : req_steps0;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          grant_d = hs_idx;
          ptr_d   = hs_idx;
          if (steps_sel != '0) begin
            state_d = S_STEP;
            cnt_d   = CW'(steps_sel);
          end else begin
            state_d = S_DWELL;
            cnt_d   = CW'(DWELL);
          end
        end
      end
      S_STEP: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_DWELL;
          cnt_d   = CW'(DWELL);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DWELL: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    button = (state_q == S_STEP);
    busy   = (state_q != S_IDLE);
    done   = 2'b00;
    if (state_q == S_DWELL && cnt_q == CW'(1)) begin
      done = grant_q ? 2'b10 : 2'b01;
    end
  end

  // Colour mirror follows the same button value the lights block samples.
  always_comb begin
    colour_d = colour_q;
    if (button) begin
      colour_d = (colour_q < 3'd6) ? colour_q + 3'd1 : 3'd0;
    end else if (colour_q == 3'd0 || colour_q == 3'd7) begin
      colour_d = 3'd1;
    end
  end

  assign colour_est = colour_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      grant_q  <= 1'b0;
      ptr_q    <= 1'b1;
      colour_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      colour_q <= colour_d;
    end
  end

endmodule

// File: tb/tb_lights_step_scheduler.sv
// Directed self-checking bench for lights_step_scheduler (CNT_W=4, DWELL=8).
module tb_lights_step_scheduler;

  localparam int unsigned CNT_W = 4;
  localparam int          DW    = 8;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [CNT_W-1:0] req_steps0;
  logic [CNT_W-1:0] req_steps1;
  logic [1:0]       req_ready;
  logic [1:0]       done;
  logic             busy;
  logic             button;
  logic [2:0]       colour_est;

  int checks;
  int failures;
  logic [2:0] seq [7];

  lights_step_scheduler #(.CNT_W(CNT_W), .DWELL(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_steps0 (req_steps0),
    .req_steps1 (req_steps1),
    .req_ready  (req_ready),
    .done       (done),
    .busy       (busy),
    .button     (button),
    .colour_est (colour_est)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, one idle cycle: leaves IDLE with colour 001.
  task automatic do_reset();
    req_valid = 2'b00;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    req_valid  = 2'b00;
    req_steps0 = '0;
    req_steps1 = '0;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (button !== 1'b0) begin failures++; $display("FAIL rst_button got=%b exp=0", button); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL rst_done got=%b exp=00", done); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
    checks++; if (colour_est !== 3'b000) begin failures++; $display("FAIL rst_colour got=%b exp=000", colour_est); end
    rst = 1'b0;
    #1;
    checks++; if (colour_est !== 3'b000) begin failures++; $display("FAIL rel_colour got=%b exp=000", colour_est); end
    tick();
    checks++; if (colour_est !== 3'b001) begin failures++; $display("FAIL idle1_colour got=%b exp=001", colour_est); end
    tick();
    checks++; if (colour_est !== 3'b001) begin failures++; $display("FAIL idle2_colour got=%b exp=001", colour_est); end
    checks++; if (button !== 1'b0) begin failures++; $display("FAIL idle_button got=%b exp=0", button); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL idle_ready got=%b exp=00", req_ready); end
  endtask

  // Single request from colour 001; checks every cycle through the return to IDLE.
  task automatic run_req(input int who, input logic [CNT_W-1:0] s);
    int         sn;
    int         n;
    logic [1:0] oh;
    logic [1:0] exp_done;
    logic [2:0] exp_col;
    sn = int'(s);
    oh = (who == 1) ? 2'b10 : 2'b01;
    if (who == 1) begin
      req_steps1 = s;
      req_steps0 = 4'd9;
    end else begin
      req_steps0 = s;
      req_steps1 = 4'd9;
    end
    req_valid = oh;
    #1;
    checks++; if (req_ready !== oh) begin failures++; $display("FAIL hs_ready%0d got=%b exp=%b", who, req_ready, oh); end
    tick();
    req_valid  = 2'b00;
    req_steps0 = 4'd15;
    req_steps1 = 4'd15;
    for (int c = 1; c <= sn + DW + 1; c++) begin
      n        = (c - 1 < sn) ? c - 1 : sn;
      exp_col  = seq[n % 7];
      exp_done = (c == sn + DW) ? oh : 2'b00;
      checks++; if (button !== (c <= sn)) begin failures++; $display("FAIL req%0d_button c=%0d got=%b exp=%b", who, c, button, (c <= sn)); end
      checks++; if (busy !== (c <= sn + DW)) begin failures++; $display("FAIL req%0d_busy c=%0d got=%b exp=%b", who, c, busy, (c <= sn + DW)); end
      checks++; if (done !== exp_done) begin failures++; $display("FAIL req%0d_done c=%0d got=%b exp=%b", who, c, done, exp_done); end
      checks++; if (colour_est !== exp_col) begin failures++; $display("FAIL req%0d_colour c=%0d got=%b exp=%b", who, c, colour_est, exp_col); end
      tick();
    end
  endtask

  task automatic test_req0_three();
    do_reset();
    run_req(0, 4'd3);
  endtask

  task automatic test_req1_seven();
    do_reset();
    run_req(1, 4'd7);
  endtask

  task automatic test_zero_steps();
    do_reset();
    run_req(0, 4'd0);
  endtask

  task automatic test_round_robin();
    int         grants[$];
    logic [1:0] dones[$];
    int         low_run;
    int         cyc;
    bit         seen;
    logic       prev_btn;
    do_reset();
    req_steps0 = 4'd2;
    req_steps1 = 4'd1;
    req_valid  = 2'b11;
    #1;
    low_run  = 0;
    cyc      = 0;
    seen     = 1'b0;
    prev_btn = 1'b0;
    while (dones.size() < 4 && cyc < 200) begin
      checks++; if (req_ready === 2'b11) begin failures++; $display("FAIL rr_ready_both cyc=%0d got=%b exp=not11", cyc, req_ready); end
      if (req_ready != 2'b00) grants.push_back(req_ready[1] ? 1 : 0);
      if (done != 2'b00) dones.push_back(done);
      if (button && !prev_btn && seen) begin
        checks++; if (low_run < DW + 1) begin failures++; $display("FAIL rr_gap got=%0d exp>=%0d", low_run, DW + 1); end
      end
      if (button) begin
        seen    = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_btn = button;
      tick();
      cyc++;
    end
    checks++; if (dones.size() != 4) begin failures++; $display("FAIL rr_timeout dones=%0d exp=4", dones.size()); end
    checks++;
    if (grants.size() < 4) begin
      failures++; $display("FAIL rr_grant_count got=%0d exp>=4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (grants[i] != i % 2) begin failures++; $display("FAIL rr_grant%0d got=%0d exp=%0d", i, grants[i], i % 2); end
      end
    end
    for (int i = 0; i < 4 && i < dones.size(); i++) begin
      checks++; if (dones[i] !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_done%0d got=%b exp=%b", i, dones[i], ((i % 2 == 1) ? 2'b10 : 2'b01)); end
    end
    req_valid = 2'b00;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_drain_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_step();
    do_reset();
    req_steps0 = 4'd5;
    req_valid  = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (button !== 1'b1) begin failures++; $display("FAIL mid_step2_button got=%b exp=1", button); end
    checks++; if (colour_est !== 3'b010) begin failures++; $display("FAIL mid_step2_colour got=%b exp=010", colour_est); end
    rst = 1'b1;
    tick();
    checks++; if (button !== 1'b0) begin failures++; $display("FAIL mid_rst_button got=%b exp=0", button); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    checks++; if (colour_est !== 3'b000) begin failures++; $display("FAIL mid_rst_colour got=%b exp=000", colour_est); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL mid_rst_done got=%b exp=00", done); end
    rst        = 1'b0;
    req_steps0 = 4'd1;
    req_steps1 = 4'd1;
    req_valid  = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_first_grant got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < DW + 2; i++) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_final_busy got=%b exp=0", busy); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_steps0 = '0;
    req_steps1 = '0;
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b011; seq[3] = 3'b100;
    seq[4] = 3'b101; seq[5] = 3'b110; seq[6] = 3'b000;
    test_reset();
    test_req0_three();
    test_req1_seven();
    test_zero_steps();
    test_round_robin();
    test_reset_mid_step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
